// File: rtl/pll_lock_phase_ctrl.sv
// pll_lock_phase_ctrl
// PLL reset/lock sequencer with system-reset qualification, automatic lock-loss
// recovery and a serialiser for dynamic phase-shift requests (PSSEL/PSDIR/PSPULSE).
// Every decision is taken on the double-flopped lock_s, never on raw pll_lock.
module pll_lock_phase_ctrl #(
   parameter int PLL_RST_CYCLES = 32,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STABLE_CYCLES  = 4096,
   parameter int PULSE_W        = 4,
   parameter int PULSE_GAP      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_lock,
   output logic       pll_rst,
   output logic       sys_rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_ch,
   input  logic       req_dir,
   input  logic [5:0] req_steps,
   output logic [2:0] ps_sel,
   output logic       ps_dir,
   output logic       ps_pulse,
   output logic       done,
   output logic       err,
   output logic [7:0] lost_cnt
);

   // One shared counter serves every timed state, so it must hold the largest limit.
   localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_B = (STABLE_CYCLES > PULSE_W) ? STABLE_CYCLES : PULSE_W;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAX_N = (MAX_C > PULSE_GAP) ? MAX_C : PULSE_GAP;
   localparam int CNT_W = $clog2(MAX_N + 1);

   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STAB_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(PULSE_GAP - 1);

   typedef enum logic [2:0] {
      ST_PRST,
      ST_WAITL,
      ST_STAB,
      ST_READY,
      ST_SETUP,
      ST_PULSE,
      ST_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       rem_q, rem_d;
   logic [2:0]       ps_sel_q, ps_sel_d;
   logic             ps_dir_q, ps_dir_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [7:0]       lost_q, lost_d;
   logic             lock_meta_q, lock_meta_d;
   logic             lock_s_q, lock_s_d;
   logic             req_active;
   logic             on_pll_clk;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Two-flop synchroniser inputs for the asynchronous LOCK pin.
   always_comb begin
      lock_meta_d = pll_lock;
      lock_s_d    = lock_meta_q;
   end

   // Control registers; all of them return to the PLL-reset condition under rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_PRST;
         cnt_q       <= '0;
         ps_sel_q    <= 3'd0;
         ps_dir_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         lost_q      <= 8'd0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ps_sel_q    <= ps_sel_d;
         ps_dir_q    <= ps_dir_d;
         done_q      <= done_d;
         err_q       <= err_d;
         lost_q      <= lost_d;
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
      end
   end

   // Remaining-step count is pure data: it is always loaded before it is used.
   always_ff @(posedge clk) begin
      rem_q <= rem_d;
   end

   // A request is in flight from SETUP until its completion done has been issued.
   assign req_active = ((state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                        (state_q == ST_GAP)) && !done_q;
   assign on_pll_clk = (state_q == ST_READY) || req_active ||
                       (state_q == ST_SETUP) || (state_q == ST_PULSE) ||
                       (state_q == ST_GAP);

   assign pll_rst   = (state_q == ST_PRST);
   assign sys_rst   = !on_pll_clk;
   assign req_ready = (state_q == ST_READY) && lock_s_q && !done_q;
   assign ps_pulse  = (state_q == ST_PULSE);
   assign ps_sel    = ps_sel_q;
   assign ps_dir    = ps_dir_q;
   assign done      = done_q;
   assign err       = err_q;
   assign lost_cnt  = lost_q;

   // Next-state and datapath-load logic for the lock sequencer and phase stepper.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      ps_sel_d = ps_sel_q;
      ps_dir_d = ps_dir_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      lost_d   = lost_q;

      unique case (state_q)
         ST_PRST: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAITL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_WAITL: begin
            if (lock_s_q) begin
               state_d = ST_STAB;
               cnt_d   = '0;
            end else if (cnt_q == WAIT_LAST) begin
               state_d = ST_PRST;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_STAB: begin
            if (!lock_s_q) begin
               state_d = ST_WAITL;
               cnt_d   = '0;
            end else if (cnt_q == STAB_LAST) begin
               state_d = ST_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_READY: begin
            if (!lock_s_q) begin
               state_d = ST_PRST;
               cnt_d   = '0;
               lost_d  = sat_inc8(lost_q);
            end else if (req_valid && req_ready) begin
               if (req_ch == 3'd7) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else if (req_steps == 6'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = ST_SETUP;
                  cnt_d    = '0;
                  ps_sel_d = req_ch;
                  ps_dir_d = req_dir;
                  rem_d    = req_steps;
               end
            end
         end

         ST_SETUP: begin
            if (!lock_s_q) begin
               state_d = ST_PRST;
               cnt_d   = '0;
               lost_d  = sat_inc8(lost_q);
               done_d  = req_active;
               err_d   = req_active;
            end else begin
               state_d = ST_PULSE;
               cnt_d   = '0;
            end
         end

         ST_PULSE: begin
            if (!lock_s_q) begin
               state_d = ST_PRST;
               cnt_d   = '0;
               lost_d  = sat_inc8(lost_q);
               done_d  = req_active;
               err_d   = req_active;
            end else if (cnt_q == PULSE_LAST) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_GAP: begin
            if (!lock_s_q) begin
               state_d = ST_PRST;
               cnt_d   = '0;
               lost_d  = sat_inc8(lost_q);
               done_d  = req_active;
               err_d   = req_active;
            end else if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               rem_d = rem_q - 6'd1;
               if (rem_q == 6'd1) begin
                  state_d = ST_READY;
               end else begin
                  state_d = ST_PULSE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = ST_PRST;
            cnt_d   = '0;
         end
      endcase

      // Completion is flagged on the final gap cycle of the last step, so that
      // acceptance-to-done latency is 1 + steps*(PULSE_W+PULSE_GAP).
      if ((state_d == ST_GAP) && (cnt_d == GAP_LAST) && (rem_d == 6'd1)) begin
         done_d = 1'b1;
         err_d  = 1'b0;
      end
   end

endmodule
